// File: rtl/packet_framer.sv
// Packet framer: prepends a two-word header (length/stream, per-stream sequence) to payload words.
// Optional `FRAMER_SEQ_CLEAR_EN adds a seq_clear input that resets every sequence counter.
module packet_framer #(
    parameter int unsigned NUM_STREAMS = 16,
    parameter logic [31:0] SEQ_START   = 32'd1
) (
    input  logic        clk,
    input  logic        reset_b,
`ifdef FRAMER_SEQ_CLEAR_EN
    input  logic        seq_clear,
`endif
    input  logic        cmd_val,
    output logic        cmd_ready,
    input  logic [15:0] cmd_stream,
    input  logic [15:0] cmd_length,
    input  logic [31:0] pay_in,
    input  logic        pay_in_val,
    output logic        pay_in_ready,
    output logic [31:0] dataOut,
    output logic        dataOut_val,
    input  logic        dataOut_ready,
    output logic        dataOut_last
);

    localparam int unsigned IdxW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    typedef enum logic [1:0] {StIdle, StHdr0, StHdr1, StPayload} state_e;

    state_e      state_q, state_d;
    logic [15:0] stream_q, stream_d;
    logic [15:0] length_q, length_d;
    logic [13:0] pay_left_q, pay_left_d;
    logic [31:0] seq_q, seq_d;
    logic [31:0] tbl_q [NUM_STREAMS];
    logic [31:0] tbl_d [NUM_STREAMS];
    logic [31:0] dout_q, dout_d;
    logic        dval_q, dval_d;
    logic        dlast_q, dlast_d;

    logic            load_en;
    logic            cmd_acc;
    logic            pay_acc;
    logic            clr;
    logic [IdxW-1:0] idx;
    logic [13:0]     words;

`ifdef FRAMER_SEQ_CLEAR_EN
    assign clr = seq_clear;
`else
    assign clr = 1'b0;
`endif

    assign idx = cmd_stream[IdxW-1:0];

    // Remainder bytes are dropped; a packet always carries at least the two header words.
    always_comb begin
        words = cmd_length[15:2];
        if (words < 14'd2) begin
            words = 14'd2;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (cmd_acc) state_d = StHdr0;
            StHdr0:    if (load_en) state_d = StHdr1;
            StHdr1:    if (load_en) state_d = (pay_left_q != 14'd0) ? StPayload : StIdle;
            StPayload: if (pay_acc && (pay_left_q == 14'd1)) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Output / handshake logic
    always_comb begin
        load_en      = !dval_q || dataOut_ready;
        cmd_ready    = (state_q == StIdle);
        pay_in_ready = (state_q == StPayload) && load_en;
        cmd_acc      = cmd_val && cmd_ready;
        pay_acc      = pay_in_val && pay_in_ready;
    end

    // Datapath next-state: command latch, sequence table and output register
    always_comb begin
        stream_d   = stream_q;
        length_d   = length_q;
        pay_left_d = pay_left_q;
        seq_d      = seq_q;
        dout_d     = dout_q;
        dval_d     = dval_q;
        dlast_d    = dlast_q;
        tbl_d      = tbl_q;

        if (clr) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                tbl_d[i] = SEQ_START;
            end
        end

        if (cmd_acc) begin
            stream_d   = cmd_stream;
            length_d   = cmd_length;
            pay_left_d = words - 14'd2;
            seq_d      = clr ? SEQ_START : tbl_q[idx];
            tbl_d[idx] = seq_d + 32'd1;
        end

        // A consumed word with nothing new to load drops valid; data is left as-is.
        if (load_en) begin
            dval_d  = 1'b0;
            dlast_d = 1'b0;
            unique case (state_q)
                StHdr0: begin
                    dout_d = {length_q[7:0], length_q[15:8], stream_q[7:0], stream_q[15:8]};
                    dval_d = 1'b1;
                end
                StHdr1: begin
                    dout_d  = {seq_q[7:0], seq_q[15:8], seq_q[23:16], seq_q[31:24]};
                    dval_d  = 1'b1;
                    dlast_d = (pay_left_q == 14'd0);
                end
                StPayload: begin
                    if (pay_acc) begin
                        dout_d     = pay_in;
                        dval_d     = 1'b1;
                        dlast_d    = (pay_left_q == 14'd1);
                        pay_left_d = pay_left_q - 14'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            stream_q   <= '0;
            length_q   <= '0;
            pay_left_q <= '0;
            seq_q      <= '0;
            dout_q     <= '0;
            dval_q     <= 1'b0;
            dlast_q    <= 1'b0;
        end else begin
            stream_q   <= stream_d;
            length_q   <= length_d;
            pay_left_q <= pay_left_d;
            seq_q      <= seq_d;
            dout_q     <= dout_d;
            dval_q     <= dval_d;
            dlast_q    <= dlast_d;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                tbl_q[i] <= SEQ_START;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
                tbl_q[i] <= tbl_d[i];
            end
        end
    end

    assign dataOut      = dout_q;
    assign dataOut_val  = dval_q;
    assign dataOut_last = dlast_q;

    // A stalled word must not change under the consumer.
    a_hold_stable: assert property (@(posedge clk) disable iff (!reset_b)
        (dval_q && !dataOut_ready) |=> (dval_q && $stable(dout_q) && $stable(dlast_q)));

    a_last_only_valid: assert property (@(posedge clk) disable iff (!reset_b)
        dlast_q |-> dval_q);

endmodule
